// File: rtl/pc_sequencer_if.sv
// Control/status bundle for pc_sequencer.
// The master side (decoder or bench) drives the control flags; the slave side (sequencer) drives the status outputs.
interface pc_sequencer_if #(
   parameter int PCW   = 10,
   parameter int DEPTH = 4
);
   localparam int DW = $clog2(DEPTH) + 1;

   logic           start;
   logic           halt;
   logic           jump;
   logic           call;
   logic           ret;
   logic [PCW-1:0] target;
   logic [1:0]     stage;
   logic [PCW-1:0] pc;
   logic           running;
   logic           done;
   logic           stack_err;
   logic [DW-1:0]  depth;

   modport master (
      output start, halt, jump, call, ret, target,
      input  stage, pc, running, done, stack_err, depth
   );

   modport slave (
      input  start, halt, jump, call, ret, target,
      output stage, pc, running, done, stack_err, depth
   );
endinterface

// File: rtl/pc_sequencer.sv
// Four-phase instruction sequencer.
// Runs a program counter with jump, call and return, backed by a small register return stack.
module pc_sequencer #(
   parameter int PCW   = 10,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           reset,
   pc_sequencer_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;
   localparam logic [PCW-1:0] PC_ONE     = 1;
   localparam logic [DW-1:0]  DEPTH_ONE  = 1;
   localparam logic [DW-1:0]  DEPTH_FULL = DW'(DEPTH);
   localparam logic [AW-1:0]  IDX_ONE    = 1;

   typedef enum logic [1:0] {
      ST_FETCH = 2'b00,
      ST_EXEC  = 2'b01,
      ST_WB    = 2'b10,
      ST_PCU   = 2'b11
   } stage_t;

   stage_t         r_stage, w_stage_next;
   logic [PCW-1:0] r_pc, w_pc_next;
   logic           r_running, w_running_next;
   logic           r_done, w_done_next;
   logic           r_err, w_err_next;
   logic [DW-1:0]  r_depth, w_depth_next;
   logic           w_push;
   logic [PCW-1:0] r_stack [DEPTH];

   logic [PCW-1:0] w_pc_inc;
   logic [AW-1:0]  w_push_idx;
   logic [AW-1:0]  w_top_idx;
   logic [PCW-1:0] w_top;
   logic           w_full;
   logic           w_empty;

   assign w_pc_inc   = r_pc + PC_ONE;
   assign w_push_idx = r_depth[AW-1:0];
   // When full, the low index bits wrap to 0, so subtracting one still lands on the top entry.
   assign w_top_idx  = w_push_idx - IDX_ONE;
   assign w_top      = r_stack[w_top_idx];
   assign w_full     = (r_depth == DEPTH_FULL);
   assign w_empty    = (r_depth == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stage   <= ST_FETCH;
         r_pc      <= '0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_depth   <= '0;
      end else begin
         r_stage   <= w_stage_next;
         r_pc      <= w_pc_next;
         r_running <= w_running_next;
         r_done    <= w_done_next;
         r_err     <= w_err_next;
         r_depth   <= w_depth_next;
      end
   end

   // Stack contents need no reset; depth alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) r_stack[w_push_idx] <= w_pc_inc;
   end

   always_comb begin
      w_stage_next   = r_stage;
      w_pc_next      = r_pc;
      w_running_next = r_running;
      w_done_next    = r_done;
      w_err_next     = r_err;
      w_depth_next   = r_depth;
      w_push         = 1'b0;
      if (!r_running) begin
         w_stage_next = ST_FETCH;
         if (bus.start) begin
            w_running_next = 1'b1;
            w_pc_next      = '0;
            w_depth_next   = '0;
            w_done_next    = 1'b0;
            w_err_next     = 1'b0;
         end
      end else begin
         case (r_stage)
            ST_FETCH: w_stage_next = ST_EXEC;
            ST_EXEC:  w_stage_next = ST_WB;
            ST_WB:    w_stage_next = ST_PCU;
            default: begin
               w_stage_next = ST_FETCH;
               // Halt outranks every transfer; ret/call act regardless of the jump flag.
               if (bus.halt) begin
                  w_running_next = 1'b0;
                  w_done_next    = 1'b1;
               end else if (bus.ret) begin
                  if (w_empty) begin
                     w_pc_next  = w_pc_inc;
                     w_err_next = 1'b1;
                  end else begin
                     w_pc_next    = w_top;
                     w_depth_next = r_depth - DEPTH_ONE;
                  end
               end else if (bus.call) begin
                  w_pc_next = bus.target;
                  if (w_full) begin
                     w_err_next = 1'b1;
                  end else begin
                     w_push       = 1'b1;
                     w_depth_next = r_depth + DEPTH_ONE;
                  end
               end else if (bus.jump) begin
                  w_pc_next = bus.target;
               end else begin
                  w_pc_next = w_pc_inc;
               end
            end
         endcase
      end
   end

   assign bus.stage     = r_stage;
   assign bus.pc        = r_pc;
   assign bus.running   = r_running;
   assign bus.done      = r_done;
   assign bus.stack_err = r_err;
   assign bus.depth     = r_depth;
endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised scoreboard bench for pc_sequencer.
// The driver feeds control flags and queues the expected next fetch; a monitor checks each fetch against that queue.
module tb_pc_sequencer;
   localparam int PCW   = 10;
   localparam int DEPTH = 4;

   logic clk;
   logic reset;

   pc_sequencer_if #(.PCW(PCW), .DEPTH(DEPTH)) vif ();

   pc_sequencer #(.PCW(PCW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (vif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int pc;
      int depth;
      int err;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad   = 0;

   // Reference model state: a plain queue stands in for the return stack.
   int ref_pc;
   int ref_err;
   int ref_stack[$];

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && vif.running && vif.stage == 2'b00) begin
         if (q.size() == 0) begin
            check("unexpected_fetch", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            $display("fetch pc=%03h depth=%0d err=%0b (exp pc=%03h depth=%0d err=%0d)",
                     vif.pc, vif.depth, vif.stack_err, e.pc, e.depth, e.err);
            check("fetch_pc", vif.pc, e.pc);
            check("fetch_depth", vif.depth, e.depth);
            check("fetch_err", vif.stack_err, e.err);
         end
      end
   end

   task automatic push_exp();
      exp_t e;
      e.pc    = ref_pc;
      e.depth = ref_stack.size();
      e.err   = ref_err;
      q.push_back(e);
   endtask

   task automatic clear_inputs();
      vif.start  = 1'b0;
      vif.halt   = 1'b0;
      vif.jump   = 1'b0;
      vif.call   = 1'b0;
      vif.ret    = 1'b0;
      vif.target = '0;
   endtask

   // Called at a negedge while idle; returns at the negedge of the first fetch.
   task automatic do_start();
      vif.start = 1'b1;
      ref_pc  = 0;
      ref_err = 0;
      ref_stack.delete();
      push_exp();
      @(negedge clk);
      vif.start = 1'b0;
      check("start_running", vif.running, 1);
      check("start_done", vif.done, 0);
      check("start_stage", vif.stage, 0);
   endtask

   // One full instruction starting at a fetch negedge. Non-PC-update phases get random junk that must be ignored.
   task automatic instr(input bit h, input bit j, input bit c, input bit r,
                        input int t, input bit st);
      for (int k = 0; k < 4; k++) begin
         check("stage_seq", vif.stage, k);
         check("running_hi", vif.running, 1);
         if (k == 3) begin
            vif.halt   = h;
            vif.jump   = j;
            vif.call   = c;
            vif.ret    = r;
            vif.target = PCW'(t);
            vif.start  = st;
            if (!h) begin
               if (r) begin
                  if (ref_stack.size() > 0) ref_pc = ref_stack.pop_back();
                  else begin
                     ref_pc  = (ref_pc + 1) % (1 << PCW);
                     ref_err = 1;
                  end
               end else if (c) begin
                  if (ref_stack.size() < DEPTH) ref_stack.push_back((ref_pc + 1) % (1 << PCW));
                  else ref_err = 1;
                  ref_pc = t;
               end else if (j) begin
                  ref_pc = t;
               end else begin
                  ref_pc = (ref_pc + 1) % (1 << PCW);
               end
               push_exp();
            end
         end else begin
            vif.halt   = 1'($urandom);
            vif.jump   = 1'($urandom);
            vif.call   = 1'($urandom);
            vif.ret    = 1'($urandom);
            vif.target = PCW'($urandom);
            vif.start  = 1'($urandom);
         end
         @(negedge clk);
      end
      clear_inputs();
      if (h) begin
         check("halt_running", vif.running, 0);
         check("halt_done", vif.done, 1);
         check("halt_pc", vif.pc, ref_pc);
         check("halt_stage", vif.stage, 0);
         check("halt_depth", vif.depth, ref_stack.size());
      end
   endtask

   task automatic plain(input int n);
      for (int i = 0; i < n; i++) instr(0, 0, 0, 0, 0, 0);
   endtask

   task automatic halt_restart();
      instr(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("idle_stage", vif.stage, 0);
      check("idle_pc", vif.pc, ref_pc);
      do_start();
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      #1;
      check("rst_stage", vif.stage, 0);
      check("rst_pc", vif.pc, 0);
      check("rst_running", vif.running, 0);
      check("rst_done", vif.done, 0);
      check("rst_err", vif.stack_err, 0);
      check("rst_depth", vif.depth, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_after_rst_running", vif.running, 0);
      check("idle_after_rst_stage", vif.stage, 0);

      // Sequential run 0..8.
      do_start();
      plain(8);

      // Call at pc=5 to 0x40, then return to 6.
      halt_restart();
      plain(5);
      instr(0, 1, 1, 0, 'h40, 0);
      instr(0, 1, 0, 1, 'h3A, 0);
      plain(1);

      // Overflow by one, then unwind past empty.
      halt_restart();
      for (int i = 0; i <= DEPTH; i++) instr(0, 1, 1, 0, int'($urandom_range(1, 1000)), 0);
      for (int i = 0; i <= DEPTH; i++) instr(0, 1, 0, 1, int'($urandom_range(0, 1023)), 0);

      // Call/ret with jump low, then PC wrap.
      halt_restart();
      instr(0, 0, 1, 0, 'h123, 0);
      instr(0, 0, 0, 1, 0, 0);
      instr(0, 1, 0, 0, 'h3FF, 0);
      plain(2);

      // Halt with jump at pc=7; start in the same cycle is ignored.
      instr(0, 1, 0, 0, 7, 0);
      instr(1, 1, 0, 0, 'h200, 1);
      check("halt7_pc", vif.pc, 7);
      @(negedge clk);
      check("halt_hold_running", vif.running, 0);
      do_start();

      // Random control mix.
      for (int n = 0; n < 150; n++) begin
         int sel;
         sel = int'($urandom_range(0, 15));
         if (sel == 0) halt_restart();
         else instr(0, sel inside {[1:4]}, sel inside {[5:7]}, sel inside {[8:10]},
                    int'($urandom_range(0, 1023)), 0);
      end

      // Asynchronous reset in writeback after a call.
      instr(0, 1, 1, 0, 'h55, 0);
      check("pre_rst_stage", vif.stage, 0);
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_stage_wb", vif.stage, 2);
      #1 reset = 1'b1;
      #1;
      check("arst_stage", vif.stage, 0);
      check("arst_pc", vif.pc, 0);
      check("arst_running", vif.running, 0);
      check("arst_done", vif.done, 0);
      check("arst_err", vif.stack_err, 0);
      check("arst_depth", vif.depth, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("post_rst_running", vif.running, 0);
      check("post_rst_pc", vif.pc, 0);
      check("queue_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter PCW, default 10, meaning program-counter width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning return-stack entries (power of two, 2..16).
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge only, except on reset.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin execution from PC 0; honoured only when not running.
REQ-006 halt  input  1  stop request; sampled only in stage 2'b11.
REQ-007 jump  input  1  taken-transfer flag from the control decoder.
REQ-008 call  input  1  call flag (arrives with jump=1).
REQ-009 ret  input  1  return flag (arrives with jump=1).
REQ-010 target  input  PCW  branch/call destination address.
REQ-011 stage  output  2  instruction phase: 00 fetch, 01 execute, 10 writeback, 11 PC update.
REQ-012 pc  output  PCW  address of the current instruction.
REQ-013 running  output  1  high while stages are sequencing.
REQ-014 done  output  1  sticky high after a halt completes.
REQ-015 stack_err  output  1  sticky; set on return-stack overflow or underflow.
REQ-016 depth  output  $clog2(DEPTH)+1  number of valid return-stack entries.

Function
REQ-017 The block SHALL hold stage at 2'b00 while running=0.
REQ-018 The block SHALL advance stage 00->01->10->11->00 one step per cycle while running=1.
REQ-019 The block SHALL sample jump/call/ret/target/halt only in the cycle where stage=2'b11 and ignore them otherwise.
REQ-020 In stage 11, the next PC SHALL be selected by priority: ret, then call, then jump, then sequential.
REQ-021 Ret with depth>0: pc <= top entry; depth decrements.
REQ-022 Ret with depth=0: pc <= pc+1; stack_err <= 1; depth stays 0.
REQ-023 Call with depth<DEPTH: push pc+1 (mod 2^PCW); depth increments; pc <= target.
REQ-024 Call with depth=DEPTH: no push; stack_err <= 1; pc <= target; contents unchanged.
REQ-025 Jump only (call=ret=0): pc <= target; stack unchanged.
REQ-026 No jump: pc <= pc+1; this SHALL wrap from 2^PCW-1 to 0 without flagging.
REQ-027 Call or ret with jump=0 SHALL still be acted on; jump is redundant for them.
REQ-028 Halt=1 in stage 11: running <= 0; done <= 1; stage <= 00; pc and stack hold.
REQ-029 Halt=1 in stage 11 SHALL override any transfer in the same cycle.
REQ-030 Start with running=0: on the next edge, running <= 1, pc <= 0, depth <= 0, done <= 0, stack_err <= 0, stage <= 00.
REQ-031 Start with running=1 SHALL be ignored.
REQ-032 Start and halt in the same stage-11 cycle: halt wins; start is ignored that cycle.
REQ-033 Latency: a transfer decided in stage 11 appears on pc in the following fetch cycle (stage 00), exactly 1 clock later.
REQ-034 Instruction period SHALL be exactly 4 clocks with no stalls.
REQ-035 Stack entries SHALL be register-based; the top entry is readable combinationally for ret.

Reset
REQ-036 Asserting reset SHALL immediately force: stage=00, pc=0, running=0, done=0, stack_err=0, depth=0, independent of clk.
REQ-037 Reset asserted mid-instruction, in any stage, SHALL abort it; no pc update or push completes.
REQ-038 After reset deasserts, the block SHALL remain idle until start.

Verification
REQ-039 Scenario: reset, then start pulse, no jumps, 8 instructions -> stage cycles 00,01,10,11; pc runs 0..8; running=1 throughout.
REQ-040 Scenario: at pc=5, call target=0x40; at 0x40, ret -> pc=0x40 next fetch, then pc=6; depth goes 1 then 0; stack_err=0.
REQ-041 Scenario: DEPTH+1 nested calls -> depth=DEPTH; stack_err=1; last call still jumps; DEPTH rets return the correct addresses; a further ret sets pc=pc+1.
REQ-042 Scenario: jump=1 asserted in stage 01 only -> ignored, pc increments; PCW=10 at pc=0x3FF, no jump -> pc=0.
REQ-043 Scenario: halt with jump=1 at pc=7 -> done=1, running=0, pc=7; later start -> pc=0, done=0.
REQ-044 Scenario: reset asserted asynchronously in stage 10 after a call -> all outputs zero before the next clk edge.
